// File: rtl/shared_port_sched.sv
// shared_port_sched: round-robin share of one WIDTH-bit resource between requesters A and B, HOLD cycles per grant
//   clk, rst_n (async active-low); req_a/req_b level requests; data_a/data_b operands sampled at grant
//   gnt_a/gnt_b one-cycle grant pulses; busy occupancy; owner current/last winner (0=A, 1=B)
//   out_valid one-cycle result strobe; out_data captured operand, held between strobes
module shared_port_sched #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             owner,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  localparam int H  = (HOLD < 1) ? 1 : HOLD;
  localparam int CW = $clog2(H) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state, state_n;
  logic             last, last_n, gnt_a_n, gnt_b_n, busy_n, owner_n, out_valid_n, win_b;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hold_q, hold_n, out_data_n;
  // on a tie the requester that did not win last time goes first
  assign win_b = req_b & (~req_a | ~last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      hold_q    <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cnt       <= cnt_n;
      hold_q    <= hold_n;
      gnt_a     <= gnt_a_n;
      gnt_b     <= gnt_b_n;
      busy      <= busy_n;
      owner     <= owner_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  always_comb begin
    state_n     = state;
    last_n      = last;
    cnt_n       = cnt;
    hold_n      = hold_q;
    gnt_a_n     = 1'b0;
    gnt_b_n     = 1'b0;
    busy_n      = busy;
    owner_n     = owner;
    out_valid_n = 1'b0;
    out_data_n  = out_data;
    if (state == IDLE && (req_a || req_b)) begin
      gnt_a_n = ~win_b;
      gnt_b_n = win_b;
      owner_n = win_b;
      hold_n  = win_b ? data_b : data_a;
      cnt_n   = CW'(H - 1);
      busy_n  = 1'b1;
      state_n = BUSY;
    end else if (state == BUSY) begin
      if (cnt != '0) cnt_n = cnt - CW'(1);
      else begin
        out_valid_n = 1'b1;
        out_data_n  = hold_q;
        busy_n      = 1'b0;
        last_n      = owner;
        state_n     = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_shared_port_sched.sv
// tb_shared_port_sched: directed self-checking bench over four parameterisations of shared_port_sched
module tb_shared_port_sched;
  logic       clk = 1'b0, rst_n = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic [3:0] ga, gb, bz, ow, ov;
  logic [7:0] od0, od2, od3;
  logic [3:0] od1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  shared_port_sched u0 (.clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .data_a(da), .data_b(db),
    .gnt_a(ga[0]), .gnt_b(gb[0]), .busy(bz[0]), .owner(ow[0]), .out_valid(ov[0]), .out_data(od0));
  shared_port_sched #(.WIDTH(4), .HOLD(2)) u1 (.clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(da[3:0]), .data_b(db[3:0]), .gnt_a(ga[1]), .gnt_b(gb[1]), .busy(bz[1]), .owner(ow[1]),
    .out_valid(ov[1]), .out_data(od1));
  shared_port_sched #(.WIDTH(8), .HOLD(1)) u2 (.clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(da), .data_b(db), .gnt_a(ga[2]), .gnt_b(gb[2]), .busy(bz[2]), .owner(ow[2]),
    .out_valid(ov[2]), .out_data(od2));
  shared_port_sched #(.WIDTH(8), .HOLD(0)) u3 (.clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(da), .data_b(db), .gnt_a(ga[3]), .gnt_b(gb[3]), .busy(bz[3]), .owner(ow[3]),
    .out_valid(ov[3]), .out_data(od3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ga, gb, bz, ow, ov} !== 20'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 00000", {ga, gb, bz, ow, ov});
    end
    checks++;
    if ({od0, od1, od2, od3} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000000", {od0, od1, od2, od3});
    end
  endtask

  // u1: WIDTH=4, HOLD=2, single A request
  task automatic test_single;
    do_reset();
    req_a = 1'b1;
    da = 8'h04;
    tick();
    req_a = 1'b0;
    checks++;
    if ({ga[1], gb[1], bz[1], ow[1], ov[1]} !== 5'b10100) begin
      errors++;
      $display("FAIL single_grant: got %b want 10100", {ga[1], gb[1], bz[1], ow[1], ov[1]});
    end
    tick();
    checks++;
    if ({ga[1], bz[1], ov[1]} !== 3'b010) begin
      errors++;
      $display("FAIL single_busy: got %b want 010", {ga[1], bz[1], ov[1]});
    end
    tick();
    checks++;
    if ({bz[1], ov[1], od1, ow[1]} !== {2'b01, 4'h4, 1'b0}) begin
      errors++;
      $display("FAIL single_done: got %b want 01_0100_0", {bz[1], ov[1], od1, ow[1]});
    end
    tick();
    checks++;
    if ({ov[1], od1} !== {1'b0, 4'h4}) begin
      errors++;
      $display("FAIL single_hold: got %b want 0_0100", {ov[1], od1});
    end
  endtask

  // u0: simultaneous requests out of reset, A first then B
  task automatic test_tie;
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    da = 8'h11;
    db = 8'h22;
    tick();
    req_a = 1'b0;
    checks++;
    if ({ga[0], gb[0], ow[0]} !== 3'b100) begin
      errors++;
      $display("FAIL tie_first: got %b want 100", {ga[0], gb[0], ow[0]});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({ov[0], od0, gb[0]} !== {1'b1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL tie_res_a: got ov=%b od=%h gb=%b want 1 11 0", ov[0], od0, gb[0]);
    end
    tick();
    req_b = 1'b0;
    checks++;
    if ({gb[0], ow[0], bz[0]} !== 3'b111) begin
      errors++;
      $display("FAIL tie_grant_b: got %b want 111", {gb[0], ow[0], bz[0]});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({ov[0], od0, ow[0]} !== {1'b1, 8'h22, 1'b1}) begin
      errors++;
      $display("FAIL tie_res_b: got ov=%b od=%h ow=%b want 1 22 1", ov[0], od0, ow[0]);
    end
  endtask

  // u0: both held for six grants, strict alternation one grant per 4 cycles
  task automatic test_alternate;
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [2:0] want;
      tick();
      want[2:1] = (i % 4 != 0) ? 2'b00 : ((i / 4) % 2 == 0) ? 2'b10 : 2'b01;
      want[0] = (i % 4 != 3);
      checks++;
      if ({ga[0], gb[0], bz[0]} !== want) begin
        errors++;
        $display("FAIL alt_cycle%0d: got %b want %b", i, {ga[0], gb[0], bz[0]}, want);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // u2 (HOLD=1) and u3 (HOLD=0): grant every 2 cycles, out_valid never with busy
  task automatic test_hold1;
    do_reset();
    req_a = 1'b1;
    da = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] want;
      tick();
      want = (i % 2 == 0) ? 3'b110 : 3'b001;
      checks++;
      if ({ga[2], bz[2], ov[2]} !== want) begin
        errors++;
        $display("FAIL hold1_cycle%0d: got %b want %b", i, {ga[2], bz[2], ov[2]}, want);
      end
      checks++;
      if ({ga[3], bz[3], ov[3]} !== want) begin
        errors++;
        $display("FAIL hold0_cycle%0d: got %b want %b", i, {ga[3], bz[3], ov[3]}, want);
      end
    end
    req_a = 1'b0;
    checks++;
    if ({od2, od3} !== 16'h5A5A) begin
      errors++;
      $display("FAIL hold1_data: got %h want 5a5a", {od2, od3});
    end
  endtask

  // u0: B request during A occupancy waits for the first IDLE edge
  task automatic test_back_to_back;
    do_reset();
    req_a = 1'b1;
    da = 8'h33;
    tick();
    req_a = 1'b0;
    req_b = 1'b1;
    db = 8'h44;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (gb[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_early_gnt%0d: got %b want 0", i, gb[0]);
      end
    end
    checks++;
    if ({ov[0], od0} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL b2b_res_a: got ov=%b od=%h want 1 33", ov[0], od0);
    end
    tick();
    req_b = 1'b0;
    checks++;
    if ({gb[0], ow[0], ov[0]} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_grant_b: got %b want 110", {gb[0], ow[0], ov[0]});
    end
  endtask

  // u0: asynchronous reset while busy
  task automatic test_async_reset;
    do_reset();
    req_a = 1'b1;
    da = 8'h55;
    tick();
    tick();
    tick();
    tick();
    req_a = 1'b0;
    req_b = 1'b1;
    db = 8'h66;
    tick();
    req_b = 1'b0;
    checks++;
    if ({gb[0], bz[0], od0} !== {2'b11, 8'h55}) begin
      errors++;
      $display("FAIL ares_pre: got gb=%b bz=%b od=%h want 1 1 55", gb[0], bz[0], od0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ga[0], gb[0], bz[0], ow[0], ov[0], od0} !== 13'h0) begin
      errors++;
      $display("FAIL ares_drop: got %h want 0000", {ga[0], gb[0], bz[0], ow[0], ov[0], od0});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ov[0], bz[0]} !== 2'b00) begin
        errors++;
        $display("FAIL ares_stale%0d: got %b want 00", i, {ov[0], bz[0]});
      end
    end
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if ({ga[0], gb[0]} !== 2'b10) begin
      errors++;
      $display("FAIL ares_tie: got %b want 10", {ga[0], gb[0]});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_hold1();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_port_sched.md
# shared_port_sched

Round-robin scheduler that shares one WIDTH-bit datapath resource between two requesters, A and B. Each grant gives the winner exclusive use of the resource for HOLD cycles. At the end of that window the block returns the captured operand as a one-cycle result. It sits between two parameterised producer ports and a single parameterised consumer. Both parameters are set per instance through named parameter override.

## Interface
Parameters:
- WIDTH, default 8: data width of both request ports and of the result.
- HOLD, default 3: occupancy in cycles per grant. Legal range ≥1; a value of 0 is treated as 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  level request from A; held until gnt_a is seen.
- req_b  input  1  level request from B; held until gnt_b is seen.
- data_a  input  WIDTH  A operand; sampled on the granting edge.
- data_b  input  WIDTH  B operand; sampled on the granting edge.
- gnt_a  output  1  one-cycle grant pulse to A.
- gnt_b  output  1  one-cycle grant pulse to B.
- busy  output  1  high while the resource is occupied.
- owner  output  1  current or last owner: 0 = A, 1 = B.
- out_valid  output  1  one-cycle result strobe.
- out_data  output  WIDTH  result: the operand captured at grant; holds its value between strobes.

## Operation
- FSM has two states: IDLE and BUSY.
- Internal state:
  - last: the previous winner.
  - cnt: occupancy counter, width clog2(HOLD)+1.
  - hold_q: captured operand, WIDTH bits.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - gnt_a = gnt_b = busy = out_valid = 0.
  - owner = 0, out_data = 0, hold_q = 0, cnt = 0.
  - last = 1, so A wins the first tie.
- IDLE, at an edge with at least one request:
  - Only one request: that requester wins.
  - Both request: the winner is the one not equal to last.
  - Actions on that edge:
    - winner's gnt goes to 1;
    - owner ← winner;
    - hold_q ← winner's data;
    - cnt ← HOLD−1;
    - busy ← 1;
    - state ← BUSY.
- IDLE with no requests: nothing changes.
- BUSY, at each edge:
  - gnt_a and gnt_b clear to 0 (a grant lasts exactly one cycle).
  - If cnt ≠ 0: cnt ← cnt−1.
  - If cnt == 0:
    - out_valid ← 1 and out_data ← hold_q;
    - busy ← 0;
    - last ← owner;
    - state ← IDLE.
- Requests are ignored in BUSY and on the completing edge. A request still high in the next IDLE cycle is arbitrated normally.
- Requesters must deassert req in the cycle gnt is visible. A req still held at the next IDLE edge is treated as a new request.
- out_valid clears on the edge after it is set.
- out_data and owner hold their values until the next completion or grant respectively.
- Operands are never modified; the result has exactly WIDTH bits, with no truncation or extension.

## Timing
- Grant at edge E0:
  - gnt and busy are high in cycle E0→E0+1.
  - busy stays high through edge E0+HOLD.
  - out_valid is high in cycle E0+HOLD→E0+HOLD+1.
- Earliest next grant is edge E0+HOLD+1, giving one grant per HOLD+1 cycles.
- With HOLD=1: grant at E0, completion at E0+1, out_valid and gnt never overlap.
- A request arriving on the completing edge is not granted until the following edge.
- Both requests continuously held (requesters re-raise after each grant): grants alternate strictly A, B, A, B…
- Reset asserted mid-BUSY:
  - all outputs return to reset values immediately, with no clock edge needed;
  - the pending result is discarded and no out_valid is emitted;
  - after reset release, arbitration restarts with A preferred.

## Test plan
- Instance with named override WIDTH=4, HOLD=2. Single req_a at E0 with data_a=4'h4 -> gnt_a pulse after E0; busy high for 2 cycles; out_valid with out_data=4'h4 after E2; owner=0.
- Default instance (WIDTH=8, HOLD=3). Simultaneous req_a/req_b out of reset, data_a=8'h11, data_b=8'h22 -> A granted first with result 8'h11 at E3; B granted at E4 with result 8'h22 at E7; owner=1.
- Both requests held continuously for 6 grants -> grant order A,B,A,B,A,B; exactly one gnt per 4 cycles; gnt_a and gnt_b never high together.
- HOLD=1 (and HOLD=0 override) -> completion one edge after grant; back-to-back grants every 2 cycles; out_valid never coincident with busy.
- req_b raised during an A occupancy -> no gnt_b until the first IDLE edge after A's out_valid; A's result is unaffected.
- rst_n pulled low asynchronously mid-BUSY -> busy, gnt and out_valid drop without a clock edge; out_data=0; no stale out_valid after release; next tie goes to A.
